// File: rtl/sc_reg_loader.sv
// sc_reg_loader: serial-to-parallel word capture for a general register.
// A word is requested with an active-low start, shifted in MSB first while
// the active-low valid qualifier is low, and once W bits have arrived the
// completed word is presented on the data bus together with a one-cycle
// active-low load strobe. An active-low abort discards a partial word.
module sc_reg_loader #(
    parameter int RegLOADER_DATAWIDTH = 8
) (
    input  logic                           SC_RegLOADER_CLOCK_50,
    input  logic                           SC_RegLOADER_RESET_InHigh,
    input  logic                           SC_RegLOADER_start_InLow,
    input  logic                           SC_RegLOADER_serial_In,
    input  logic                           SC_RegLOADER_valid_InLow,
    input  logic                           SC_RegLOADER_abort_InLow,
    output logic [RegLOADER_DATAWIDTH-1:0] SC_RegLOADER_data_OutBUS,
    output logic                           SC_RegLOADER_load_OutLow,
    output logic                           SC_RegLOADER_busy_OutHigh
);

    localparam int W    = RegLOADER_DATAWIDTH;
    localparam int CntW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } loaderState_t;

    loaderState_t    state_q;
    logic [W-1:0]    shiftReg_q;
    logic [CntW-1:0] bitCount_q;
    logic [W-1:0]    data_q;
    logic            loadN_q;
    logic            busy_q;

    logic [W-1:0]    shiftReg_d;

    // Shift register contents after accepting the bit currently on the serial line
    always_comb begin
        shiftReg_d = {shiftReg_q[W-2:0], SC_RegLOADER_serial_In};
    end

    // Capture FSM: every output is a flop so the load strobe cannot glitch
    always_ff @(posedge SC_RegLOADER_CLOCK_50) begin
        if (SC_RegLOADER_RESET_InHigh) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            bitCount_q <= '0;
            data_q     <= '0;
            loadN_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    loadN_q <= 1'b1;
                    if (!SC_RegLOADER_start_InLow) begin
                        state_q    <= SHIFT;
                        shiftReg_q <= '0;
                        bitCount_q <= '0;
                        busy_q     <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end

                SHIFT: begin
                    loadN_q <= 1'b1;
                    if (!SC_RegLOADER_abort_InLow) begin
                        state_q    <= IDLE;
                        bitCount_q <= '0;
                        busy_q     <= 1'b0;
                    end else if (!SC_RegLOADER_valid_InLow) begin
                        shiftReg_q <= shiftReg_d;
                        if (bitCount_q == LastBit) begin
                            state_q    <= LOAD;
                            bitCount_q <= '0;
                            data_q     <= shiftReg_d;
                            loadN_q    <= 1'b0;
                        end else begin
                            bitCount_q <= bitCount_q + 1'b1;
                        end
                    end
                end

                LOAD: begin
                    state_q <= IDLE;
                    loadN_q <= 1'b1;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q    <= IDLE;
                    shiftReg_q <= '0;
                    bitCount_q <= '0;
                    loadN_q    <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign SC_RegLOADER_data_OutBUS  = data_q;
    assign SC_RegLOADER_load_OutLow  = loadN_q;
    assign SC_RegLOADER_busy_OutHigh = busy_q;

endmodule

// File: tb/tb_sc_reg_loader.sv
// tb_sc_reg_loader: directed scenarios for the serial register loader (W=8).
module tb_sc_reg_loader;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         startN;
    logic         serialIn;
    logic         validN;
    logic         abortN;
    logic [W-1:0] dataOut;
    logic         loadN;
    logic         busy;

    int assertCount;
    int failCount;
    int strobeCount;
    int strobeBase;

    sc_reg_loader #(
        .RegLOADER_DATAWIDTH(W)
    ) dut (
        .SC_RegLOADER_CLOCK_50    (clk),
        .SC_RegLOADER_RESET_InHigh(rst),
        .SC_RegLOADER_start_InLow (startN),
        .SC_RegLOADER_serial_In   (serialIn),
        .SC_RegLOADER_valid_InLow (validN),
        .SC_RegLOADER_abort_InLow (abortN),
        .SC_RegLOADER_data_OutBUS (dataOut),
        .SC_RegLOADER_load_OutLow (loadN),
        .SC_RegLOADER_busy_OutHigh(busy)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobe cycles mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (loadN === 1'b0) strobeCount++;
    end

    // Hard stop in case a scenario never returns
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shift W bits MSB first, optionally with 1-3 idle cycles between bits
    task automatic shiftBits(input logic [W-1:0] word, input bit useGaps);
        for (int i = W - 1; i >= 0; i--) begin
            if (useGaps && i < W - 1) begin
                int gap;
                gap = $urandom_range(1, 3);
                for (int g = 0; g < gap; g++) begin
                    validN   = 1'b1;
                    serialIn = ~word[i];
                    step();
                end
            end
            validN   = 1'b0;
            serialIn = word[i];
            step();
        end
        validN   = 1'b1;
        serialIn = 1'b0;
    endtask

    // Request a word and shift it in; returns just after the edge of bit W
    task automatic applyStimulus(input logic [W-1:0] word, input bit useGaps);
        startN = 1'b0;
        step();
        startN = 1'b1;
        shiftBits(word, useGaps);
    endtask

    task automatic test_reset();
        rst = 1'b1; startN = 1'b1; validN = 1'b1; abortN = 1'b1; serialIn = 1'b0;
        step();
        step();
        rst = 1'b0;
        assertCount++;
        if (dataOut !== 8'h00) begin failCount++; $display("[TB] FAIL reset_data: got %h expected 00", dataOut); end
        assertCount++;
        if (loadN !== 1'b1) begin failCount++; $display("[TB] FAIL reset_load: got %b expected 1", loadN); end
        assertCount++;
        if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        strobeBase = strobeCount;
        startN = 1'b0;
        step();
        startN = 1'b1;
        assertCount++;
        if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL basic_busy_start: got %b expected 1", busy); end
        shiftBits(8'hA5, 1'b0);
        assertCount++;
        if (loadN !== 1'b0) begin failCount++; $display("[TB] FAIL basic_strobe: got %b expected 0", loadN); end
        assertCount++;
        if (dataOut !== 8'hA5) begin failCount++; $display("[TB] FAIL basic_data: got %h expected a5", dataOut); end
        assertCount++;
        if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL basic_busy_load: got %b expected 1", busy); end
        step();
        assertCount++;
        if (loadN !== 1'b1 || busy !== 1'b0) begin
            failCount++; $display("[TB] FAIL basic_after: got load=%b busy=%b expected load=1 busy=0", loadN, busy);
        end
        assertCount++;
        if (strobeCount - strobeBase !== 1) begin
            failCount++; $display("[TB] FAIL basic_strobe_count: got %0d expected 1", strobeCount - strobeBase);
        end
    endtask

    task automatic test_gaps();
        strobeBase = strobeCount;
        applyStimulus(8'h3C, 1'b1);
        assertCount++;
        if (loadN !== 1'b0 || dataOut !== 8'h3C) begin
            failCount++; $display("[TB] FAIL gaps_data: got load=%b data=%h expected load=0 data=3c", loadN, dataOut);
        end
        step();
        step();
        assertCount++;
        if (strobeCount - strobeBase !== 1) begin
            failCount++; $display("[TB] FAIL gaps_strobe_count: got %0d expected 1", strobeCount - strobeBase);
        end
        assertCount++;
        if (dataOut !== 8'h3C || busy !== 1'b0) begin
            failCount++; $display("[TB] FAIL gaps_hold: got data=%h busy=%b expected data=3c busy=0", dataOut, busy);
        end
    endtask

    task automatic test_abort();
        // Reload 0xA5 as the known previous word
        applyStimulus(8'hA5, 1'b0);
        step();
        strobeBase = strobeCount;
        startN = 1'b0;
        step();
        startN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            validN = 1'b0; serialIn = 1'b1;
            step();
        end
        abortN = 1'b0; validN = 1'b0; serialIn = 1'b1;
        step();
        abortN = 1'b1; validN = 1'b1;
        assertCount++;
        if (busy !== 1'b0 || loadN !== 1'b1) begin
            failCount++; $display("[TB] FAIL abort_idle: got busy=%b load=%b expected busy=0 load=1", busy, loadN);
        end
        // Further valid bits must not be captured while idle
        for (int i = 0; i < 10; i++) begin
            validN = 1'b0; serialIn = 1'b1;
            step();
        end
        validN = 1'b1;
        assertCount++;
        if (dataOut !== 8'hA5 || strobeCount !== strobeBase || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL abort_hold: got data=%h strobes=%0d busy=%b expected data=a5 strobes=0 busy=0",
                     dataOut, strobeCount - strobeBase, busy);
        end
        applyStimulus(8'hFF, 1'b0);
        assertCount++;
        if (dataOut !== 8'hFF || loadN !== 1'b0) begin
            failCount++; $display("[TB] FAIL abort_next_word: got data=%h load=%b expected data=ff load=0", dataOut, loadN);
        end
        // Abort during the strobe cycle is ignored
        abortN = 1'b0;
        step();
        abortN = 1'b1;
        assertCount++;
        if (strobeCount - strobeBase !== 1 || dataOut !== 8'hFF || loadN !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL abort_in_load: got strobes=%0d data=%h load=%b expected strobes=1 data=ff load=1",
                     strobeCount - strobeBase, dataOut, loadN);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w;
        w = 8'h5A;
        strobeBase = strobeCount;
        startN = 1'b0;
        step();
        startN = 1'b1;
        for (int i = W - 1; i >= W - 5; i--) begin
            validN = 1'b0; serialIn = w[i];
            step();
        end
        rst = 1'b1; validN = 1'b0; serialIn = w[2];
        step();
        rst = 1'b0; validN = 1'b1;
        assertCount++;
        if (dataOut !== 8'h00 || loadN !== 1'b1 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midreset_values: got data=%h load=%b busy=%b expected data=00 load=1 busy=0",
                     dataOut, loadN, busy);
        end
        for (int i = 0; i < 4; i++) begin
            validN = 1'b0; serialIn = 1'b1;
            step();
        end
        validN = 1'b1;
        assertCount++;
        if (strobeCount !== strobeBase || busy !== 1'b0) begin
            failCount++; $display("[TB] FAIL midreset_no_strobe: got strobes=%0d busy=%b expected 0 and 0",
                                  strobeCount - strobeBase, busy);
        end
        applyStimulus(8'h5A, 1'b0);
        assertCount++;
        if (dataOut !== 8'h5A || loadN !== 1'b0) begin
            failCount++; $display("[TB] FAIL midreset_reload: got data=%h load=%b expected data=5a load=0", dataOut, loadN);
        end
        step();
        // A reset pulse that never spans a rising edge must do nothing
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        step();
        assertCount++;
        if (dataOut !== 8'h5A) begin
            failCount++; $display("[TB] FAIL reset_between_edges: got %h expected 5a", dataOut);
        end
    endtask

    task automatic test_back_to_back();
        strobeBase = strobeCount;
        startN = 1'b0;
        step();
        shiftBits(8'h81, 1'b0);
        assertCount++;
        if (loadN !== 1'b0 || dataOut !== 8'h81) begin
            failCount++; $display("[TB] FAIL b2b_first: got load=%b data=%h expected load=0 data=81", loadN, dataOut);
        end
        step();
        assertCount++;
        if (loadN !== 1'b1 || busy !== 1'b0) begin
            failCount++; $display("[TB] FAIL b2b_idle_gap: got load=%b busy=%b expected load=1 busy=0", loadN, busy);
        end
        step();
        startN = 1'b1;
        assertCount++;
        if (busy !== 1'b1) begin
            failCount++; $display("[TB] FAIL b2b_restart: got busy=%b expected 1", busy);
        end
        shiftBits(8'h7E, 1'b0);
        assertCount++;
        if (loadN !== 1'b0 || dataOut !== 8'h7E) begin
            failCount++; $display("[TB] FAIL b2b_second: got load=%b data=%h expected load=0 data=7e", loadN, dataOut);
        end
        step();
        step();
        assertCount++;
        if (strobeCount - strobeBase !== 2 || busy !== 1'b0) begin
            failCount++; $display("[TB] FAIL b2b_strobes: got strobes=%0d busy=%b expected strobes=2 busy=0",
                                  strobeCount - strobeBase, busy);
        end
    endtask

    // Scenario sequence
    initial begin
        assertCount = 0;
        failCount   = 0;
        strobeCount = 0;
        strobeBase  = 0;
        rst = 1'b1; startN = 1'b1; validN = 1'b1; abortN = 1'b1; serialIn = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
